// File: rtl/multiply_arbiter_pkg.sv
// ============================================================================
// Module : multiply_arbiter_pkg
// Brief  : Shared constants and grant helper for the two-client multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multiply_arbiter_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Winner among the valid requesters; contested grants go to the one not served last when fair.
    function automatic logic pick_winner(input logic v0, input logic v1,
                                         input logic last_grant, input logic fair);
        logic w;
        w = REQ0;
        if (v1 && !v0) begin
            w = REQ1;
        end else if (v0 && v1 && fair) begin
            w = ~last_grant;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multiply_arbiter_if.sv
// ============================================================================
// Module : multiply_arbiter_if
// Brief  : Request/response handshake bundle between two clients and the arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multiply_arbiter_if ();
    import multiply_arbiter_pkg::*;

    logic              Req0_Valid;
    logic [OP_W-1:0]   Req0_A;
    logic [OP_W-1:0]   Req0_B;
    logic              Req0_Ready;
    logic              Req1_Valid;
    logic [OP_W-1:0]   Req1_A;
    logic [OP_W-1:0]   Req1_B;
    logic              Req1_Ready;
    logic              Rsp_Valid;
    logic              Rsp_Ready;
    logic              Rsp_Id;
    logic [PROD_W-1:0] Rsp_Product;
    logic              Busy;

    modport master (
        output Req0_Valid, Req0_A, Req0_B, Req1_Valid, Req1_A, Req1_B, Rsp_Ready,
        input  Req0_Ready, Req1_Ready, Rsp_Valid, Rsp_Id, Rsp_Product, Busy
    );

    modport slave (
        input  Req0_Valid, Req0_A, Req0_B, Req1_Valid, Req1_A, Req1_B, Rsp_Ready,
        output Req0_Ready, Req1_Ready, Rsp_Valid, Rsp_Id, Rsp_Product, Busy
    );

endinterface

`default_nettype wire

// File: rtl/multiply_arbiter_multiply.sv
// ============================================================================
// Module : multiply
// Brief  : Combinational 4x4 unsigned multiplier with full 8-bit product.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multiply (
    input  wire logic [3:0] a,
    input  wire logic [3:0] b,
    output logic      [7:0] p
);

    assign p = {4'b0000, a} * {4'b0000, b};

endmodule

`default_nettype wire

// File: rtl/multiply_arbiter.sv
// ============================================================================
// Module : multiply_arbiter
// Brief  : Two-requester front end sharing one multiplier, registered response.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multiply_arbiter
    import multiply_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    multiply_arbiter_if.slave     bus
);

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic              last_grant;
    logic              winner;
    logic              grant0;
    logic              grant1;
    logic              handshake;
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic              rsp_id;
    logic [PROD_W-1:0] rsp_product;
    logic [PROD_W-1:0] prod;

    multiply u_multiply (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    always_comb begin
        winner    = pick_winner(bus.Req0_Valid, bus.Req1_Valid, last_grant, FAIR);
        grant0    = (state == IDLE) && bus.Req0_Valid && (winner == REQ0);
        grant1    = (state == IDLE) && bus.Req1_Valid && (winner == REQ1);
        handshake = grant0 || grant1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (handshake) state_nx = CALC;
            CALC:    state_nx = RESP;
            RESP:    if (bus.Rsp_Ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.Req0_Ready  = grant0;
        bus.Req1_Ready  = grant1;
        bus.Rsp_Valid   = (state == RESP);
        bus.Busy        = (state != IDLE);
        bus.Rsp_Id      = rsp_id;
        bus.Rsp_Product = rsp_product;
    end

    // Operands and id are only loaded in IDLE, so the response stays frozen through RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a        <= '0;
            op_b        <= '0;
            rsp_id      <= REQ0;
            last_grant  <= REQ1;
            rsp_product <= '0;
        end else begin
            if (handshake) begin
                op_a       <= grant1 ? bus.Req1_A : bus.Req0_A;
                op_b       <= grant1 ? bus.Req1_B : bus.Req0_B;
                rsp_id     <= winner;
                last_grant <= winner;
            end
            if (state == CALC) begin
                rsp_product <= prod;
            end
        end
    end

endmodule

`default_nettype wire
